capture_stream_packer: RTL and testbench
========================================

// Module: capture_stream_packer
// PURPOSE
//   Write-side counterpart of the display read path. Accepts an 8-bit camera pixel stream on fclk,
//   packs 8 pixels into 64-bit little-endian words (first pixel in [7:0]), buffers them, and
//   offers them to the AXI write master in bursts. Frames are armed and stopped by the same
//   32-bit command channel format the display uses (`CMD_START / `CMD_STOP).
// PARAMETERS
//   FRAME_PIXELS  307200  pixels per frame; must be a multiple of 8*BURST_LEN
//   BURST_LEN     16      64-bit words per AXI write burst
//   DEPTH         64      word buffer depth; power of 2, >= 2*BURST_LEN
// PORTS
//   fclk               in   1   clock
//   rst                in   1   synchronous reset, active-high
//   cmd                in   32  command word
//   cmd_valid          in   1   command strobe
//   cmd_ready          out  1   always 1; a command is consumed in the cycle it is valid
//   pix_valid          in   1   pixel strobe
//   pix_sof            in   1   qualifies pix_valid: this pixel is the first of a frame
//   pix_data           in   8   pixel
//   pix_ready          out  1   always 1; the camera cannot stall
//   wdata              out  64  packed word at buffer head
//   wdata_valid        out  1   buffer not empty
//   wdata_ready        in   1   word consumed when wdata_valid && wdata_ready
//   wdata_burst_valid  out  1   buffer holds >= BURST_LEN words
//   frame_done         out  1   1-cycle pulse when a frame's last word leaves the buffer
//   overflow_err       out  1   sticky; a packed word was dropped
//   sof_err            out  1   sticky; sof seen mid-frame
//   debug              out  8   {3'b0, overflow_err, sof_err, state[2:0]}
// BEHAVIOUR
//   Reset: state IDLE, stopping 0, pack count 0, pixel count 0, buffer empty, all outputs 0
//     except cmd_ready and pix_ready (1). Reset mid-frame discards all buffered data.
//   Commands (cmd_valid high): `CMD_START -> clear stopping; IDLE->ARMED. `CMD_STOP -> set
//     stopping; ARMED->IDLE immediately. Other values ignored. START in non-IDLE state: no effect
//     except clearing stopping.
//   States:
//     IDLE    pixels ignored.
//     ARMED   pixels without sof ignored; pix_valid&&pix_sof -> CAPTURE, that pixel is pixel 0.
//     CAPTURE each pix_valid packs pix_data into byte lane (pixel count mod 8); the 8th byte
//             completes a word pushed next cycle. After pixel FRAME_PIXELS-1 -> DRAIN.
//             pix_sof during CAPTURE (except pixel 0) sets sof_err; pixel still packed, no resync.
//     DRAIN   pixels ignored; when buffer empty: frame_done=1 for one cycle, then ARMED
//             (stopping=0) or IDLE (stopping=1, stopping cleared).
//   Counters: 19-bit pixel count, cleared on entry to CAPTURE; 3-bit byte lane, wraps 7->0.
//   Buffer: FWFT; wdata/wdata_valid reflect head in same cycle as a word is present.
//     Push latency: 8th pixel at cycle N -> wdata_valid at N+2 if buffer was empty.
//     Push when full and no pop same cycle: word dropped, overflow_err set, counts continue.
//     Push and pop same cycle when full: both succeed, occupancy unchanged.
//   wdata_burst_valid = occupancy >= BURST_LEN, registered from occupancy (no extra lag vs count).
//   Errors clear only on rst.
// TESTING
//   START, one frame of FRAME_PIXELS=128 (test param) pixels 0..127, wdata_ready=1 ->
//     16 words, word0=64'h0706050403020100, frame_done once, back to ARMED.
//   Pixels before sof while ARMED -> ignored; first word begins at sof pixel value.
//   wdata_ready=0 for a frame of 64*8+8 pixels, DEPTH=64 -> overflow_err=1, exactly 64 words held.
//   STOP mid-CAPTURE -> frame completes, frame_done pulses, state IDLE; next sof ignored.
//   sof at pixel 40 -> sof_err=1, frame still ends after FRAME_PIXELS pixels.
//   wdata_burst_valid low at 15 words, high at 16; rst mid-frame -> all outputs to reset values.

Source files
------------

// File: rtl/capture_stream_packer.sv
// Camera capture packer: packs 8-bit pixels into 64-bit little-endian words and buffers
// them in a FWFT FIFO for an AXI write master. Frames are armed and stopped by commands.
module capture_stream_packer #(
    parameter int          FRAME_PIXELS = 307200,
    parameter int          BURST_LEN    = 16,
    parameter int          DEPTH        = 64,
    parameter logic [31:0] CMD_START    = 32'h0000_0001,
    parameter logic [31:0] CMD_STOP     = 32'h0000_0002
) (
    input  logic        fclk,
    input  logic        rst,
    input  logic [31:0] cmd,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        pix_valid,
    input  logic        pix_sof,
    input  logic [7:0]  pix_data,
    output logic        pix_ready,
    output logic [63:0] wdata,
    output logic        wdata_valid,
    input  logic        wdata_ready,
    output logic        wdata_burst_valid,
    output logic        frame_done,
    output logic        overflow_err,
    output logic        sof_err,
    output logic [7:0]  debug
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [18:0]   LAST_PIX  = 19'(FRAME_PIXELS - 1);
    localparam logic [CW-1:0] FULL_CNT  = CW'(DEPTH);
    localparam logic [CW-1:0] BURST_CNT = CW'(BURST_LEN);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ARMED   = 3'd1,
        S_CAPTURE = 3'd2,
        S_DRAIN   = 3'd3
    } state_t;

    state_t          state_q, state_d;
    logic            stopping_q, stopping_d;
    logic [18:0]     pix_cnt_q, pix_cnt_d;
    logic [2:0]      lane_q, lane_d;
    logic [63:0]     pack_q, pack_d;
    logic            push_q, push_d;
    logic [63:0]     push_word_q, push_word_d;
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic            burst_q, burst_d;
    logic            overflow_q, overflow_d;
    logic            sof_err_q, sof_err_d;
    logic [63:0]     mem_q [DEPTH];

    logic cmd_start, cmd_stop;
    logic buf_empty, buf_full, pop, wr_en;

    assign cmd_start = cmd_valid && (cmd == CMD_START);
    assign cmd_stop  = cmd_valid && (cmd == CMD_STOP);
    assign buf_empty = (count_q == '0);
    assign buf_full  = (count_q == FULL_CNT);
    assign pop       = !buf_empty && wdata_ready;
    // A push into a full buffer only lands if a pop frees the slot in the same cycle.
    assign wr_en     = push_q && (!buf_full || pop);

    always_comb begin
        state_d     = state_q;
        stopping_d  = stopping_q;
        pix_cnt_d   = pix_cnt_q;
        lane_d      = lane_q;
        pack_d      = pack_q;
        push_d      = 1'b0;
        push_word_d = push_word_q;
        sof_err_d   = sof_err_q;
        frame_done  = 1'b0;

        if (cmd_start) stopping_d = 1'b0;
        if (cmd_stop)  stopping_d = 1'b1;

        case (state_q)
            S_IDLE: begin
                if (cmd_start) state_d = S_ARMED;
            end
            S_ARMED: begin
                if (cmd_stop) begin
                    state_d = S_IDLE;
                end else if (pix_valid && pix_sof) begin
                    // The sof pixel is pixel 0, so counters restart already past it.
                    state_d     = S_CAPTURE;
                    pack_d[7:0] = pix_data;
                    pix_cnt_d   = 19'd1;
                    lane_d      = 3'd1;
                end
            end
            S_CAPTURE: begin
                if (pix_valid) begin
                    pack_d[{lane_q, 3'b000} +: 8] = pix_data;
                    lane_d    = lane_q + 3'd1;
                    pix_cnt_d = pix_cnt_q + 19'd1;
                    if (pix_sof) sof_err_d = 1'b1;
                    if (lane_q == 3'd7) begin
                        push_d      = 1'b1;
                        push_word_d = {pix_data, pack_q[55:0]};
                    end
                    if (pix_cnt_q == LAST_PIX) state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (buf_empty && !push_q) begin
                    frame_done = 1'b1;
                    state_d    = stopping_d ? S_IDLE : S_ARMED;
                    stopping_d = 1'b0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        if (wr_en) wr_ptr_d = wr_ptr_q + AW'(1);
        if (pop)   rd_ptr_d = rd_ptr_q + AW'(1);
        if (wr_en && !pop)      count_d = count_q + CW'(1);
        else if (!wr_en && pop) count_d = count_q - CW'(1);
        if (push_q && !wr_en) overflow_d = 1'b1;
        burst_d = (count_d >= BURST_CNT);
    end

    always_ff @(posedge fclk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            stopping_q <= 1'b0;
            pix_cnt_q  <= '0;
            lane_q     <= '0;
            push_q     <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            burst_q    <= 1'b0;
            overflow_q <= 1'b0;
            sof_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            stopping_q <= stopping_d;
            pix_cnt_q  <= pix_cnt_d;
            lane_q     <= lane_d;
            push_q     <= push_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            burst_q    <= burst_d;
            overflow_q <= overflow_d;
            sof_err_q  <= sof_err_d;
        end
    end

    // Datapath storage carries no reset; validity is tracked by the control flops above.
    always_ff @(posedge fclk) begin
        pack_q      <= pack_d;
        push_word_q <= push_word_d;
        if (wr_en) mem_q[wr_ptr_q] <= push_word_q;
    end

    assign cmd_ready         = 1'b1;
    assign pix_ready         = 1'b1;
    assign wdata_valid       = !buf_empty;
    assign wdata             = buf_empty ? 64'd0 : mem_q[rd_ptr_q];
    assign wdata_burst_valid = burst_q;
    assign overflow_err      = overflow_q;
    assign sof_err           = sof_err_q;
    assign debug             = {3'b000, overflow_q, sof_err_q, state_q};

endmodule

// File: tb/tb_capture_stream_packer.sv
// Scoreboard bench for capture_stream_packer: expected words are queued from the pixels
// sent and popped by a monitor on every accepted output word.
module tb_capture_stream_packer;

    localparam int          FP    = 128;
    localparam int          FPB   = 640;
    localparam int          BL    = 16;
    localparam int          DEP   = 64;
    localparam logic [31:0] C_START = 32'h0000_0001;
    localparam logic [31:0] C_STOP  = 32'h0000_0002;

    logic        fclk = 1'b0;
    logic        rst;
    logic [31:0] cmd;
    logic        cmd_valid, cmd_ready;
    logic        pix_valid, pix_sof, pix_ready;
    logic [7:0]  pix_data;
    logic [63:0] wdata;
    logic        wdata_valid, wdata_ready, wdata_burst_valid, frame_done;
    logic        overflow_err, sof_err;
    logic [7:0]  debug;

    logic [31:0] b_cmd;
    logic        b_cmd_valid, b_cmd_ready;
    logic        b_pix_valid, b_pix_sof, b_pix_ready;
    logic [7:0]  b_pix_data;
    logic [63:0] b_wdata;
    logic        b_wdata_valid, b_wdata_ready, b_wdata_burst_valid, b_frame_done;
    logic        b_overflow_err, b_sof_err;
    logic [7:0]  b_debug;

    capture_stream_packer #(.FRAME_PIXELS(FP), .BURST_LEN(BL), .DEPTH(DEP),
                            .CMD_START(C_START), .CMD_STOP(C_STOP)) dut (
        .fclk(fclk), .rst(rst), .cmd(cmd), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .pix_valid(pix_valid), .pix_sof(pix_sof), .pix_data(pix_data), .pix_ready(pix_ready),
        .wdata(wdata), .wdata_valid(wdata_valid), .wdata_ready(wdata_ready),
        .wdata_burst_valid(wdata_burst_valid), .frame_done(frame_done),
        .overflow_err(overflow_err), .sof_err(sof_err), .debug(debug));

    capture_stream_packer #(.FRAME_PIXELS(FPB), .BURST_LEN(BL), .DEPTH(DEP),
                            .CMD_START(C_START), .CMD_STOP(C_STOP)) dut_b (
        .fclk(fclk), .rst(rst), .cmd(b_cmd), .cmd_valid(b_cmd_valid), .cmd_ready(b_cmd_ready),
        .pix_valid(b_pix_valid), .pix_sof(b_pix_sof), .pix_data(b_pix_data), .pix_ready(b_pix_ready),
        .wdata(b_wdata), .wdata_valid(b_wdata_valid), .wdata_ready(b_wdata_ready),
        .wdata_burst_valid(b_wdata_burst_valid), .frame_done(b_frame_done),
        .overflow_err(b_overflow_err), .sof_err(b_sof_err), .debug(b_debug));

    always #5 fclk = ~fclk;

    int          checks = 0;
    int          failures = 0;
    int          got_done = 0;
    int          exp_done = 0;
    int          words_seen = 0;
    logic [63:0] first_word_seen = '0;
    logic [63:0] exp_q[$];
    logic [63:0] mon_exp;
    logic [7:0]  frame_px [FP];
    bit          rnd_ready = 1'b0;
    bit          fixed_ready = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge fclk);
        #1;
    endtask

    // Reference: 8 consecutive pixels form one word, first pixel in the low byte.
    function automatic void build_words();
        for (int w = 0; w < FP / 8; w++) begin
            logic [63:0] wd;
            wd = '0;
            for (int j = 0; j < 8; j++) wd[8*j +: 8] = frame_px[8*w + j];
            exp_q.push_back(wd);
        end
    endfunction

    function automatic void random_frame();
        for (int i = 0; i < FP; i++) frame_px[i] = 8'($urandom_range(0, 255));
    endfunction

    task automatic command(input logic [31:0] c);
        cmd = c;
        cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
        cmd = '0;
    endtask

    task automatic junk(input int n);
        for (int i = 0; i < n; i++) begin
            pix_valid = 1'b1;
            pix_sof   = 1'b0;
            pix_data  = 8'($urandom_range(0, 255));
            tick();
        end
        pix_valid = 1'b0;
    endtask

    task automatic send_range(input int lo, input int hi, input int sof_at, input bit gaps);
        for (int i = lo; i <= hi; i++) begin
            if (gaps) begin
                while ($urandom_range(0, 3) == 0) begin
                    pix_valid = 1'b0;
                    pix_sof   = 1'($urandom_range(0, 1));
                    tick();
                end
            end
            pix_valid = 1'b1;
            pix_sof   = (i == 0) || (i == sof_at);
            pix_data  = frame_px[i];
            tick();
        end
        pix_valid = 1'b0;
        pix_sof   = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int n;
        n = 0;
        while (got_done != exp_done && n < 3000) begin
            tick();
            n++;
        end
        chk(name, 64'(got_done), 64'(exp_done));
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_cmd_ready"}, 64'(cmd_ready), 64'd1);
        chk({tag, "_pix_ready"}, 64'(pix_ready), 64'd1);
        chk({tag, "_wdata_valid"}, 64'(wdata_valid), 64'd0);
        chk({tag, "_wdata"}, wdata, 64'd0);
        chk({tag, "_burst"}, 64'(wdata_burst_valid), 64'd0);
        chk({tag, "_frame_done"}, 64'(frame_done), 64'd0);
        chk({tag, "_overflow"}, 64'(overflow_err), 64'd0);
        chk({tag, "_sof_err"}, 64'(sof_err), 64'd0);
        chk({tag, "_debug"}, 64'(debug), 64'd0);
    endtask

    initial begin
        wdata_ready = 1'b0;
        forever begin
            @(posedge fclk);
            #1;
            wdata_ready = rnd_ready ? 1'($urandom_range(0, 1)) : fixed_ready;
        end
    end

    always @(negedge fclk) begin
        if (!rst) begin
            if (wdata_valid && wdata_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_word: got %0h expected none", wdata);
                end else begin
                    mon_exp = exp_q.pop_front();
                    chk("word", wdata, mon_exp);
                    if (words_seen == 0) first_word_seen = wdata;
                    words_seen++;
                end
            end
            if (frame_done) got_done++;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int snap, n;
        rst = 1'b1;
        cmd = '0; cmd_valid = 1'b0;
        pix_valid = 1'b0; pix_sof = 1'b0; pix_data = '0;
        b_cmd = '0; b_cmd_valid = 1'b0;
        b_pix_valid = 1'b0; b_pix_sof = 1'b0; b_pix_data = '0; b_wdata_ready = 1'b0;
        repeat (3) tick();
        check_reset_outputs("reset");
        rst = 1'b0;
        tick();

        // Ordered frame 0..127 with junk before sof
        fixed_ready = 1'b1;
        command(C_START);
        chk("armed_after_start", 64'(debug[2:0]), 64'd1);
        junk(5);
        for (int i = 0; i < FP; i++) frame_px[i] = 8'(i);
        build_words();
        exp_done++;
        send_range(0, FP - 1, -1, 1'b0);
        wait_done("frame_done_ordered");
        chk("word0", first_word_seen, 64'h0706050403020100);
        chk("words_ordered", 64'(words_seen), 64'd16);
        chk("armed_after_frame", 64'(debug[2:0]), 64'd1);

        // Random frames, random gaps and backpressure
        rnd_ready = 1'b1;
        for (int f = 0; f < 3; f++) begin
            random_frame();
            junk($urandom_range(0, 6));
            build_words();
            exp_done++;
            send_range(0, FP - 1, -1, 1'b1);
            wait_done("frame_done_random");
        end
        rnd_ready = 1'b0;
        chk("random_queue_empty", 64'(exp_q.size()), 64'd0);
        chk("no_overflow", 64'(overflow_err), 64'd0);
        chk("no_sof_err", 64'(sof_err), 64'd0);

        // Spurious sof at pixel 40
        random_frame();
        build_words();
        exp_done++;
        send_range(0, FP - 1, 40, 1'b0);
        wait_done("frame_done_sof40");
        chk("sof_err_set", 64'(sof_err), 64'd1);
        chk("sof40_state", 64'(debug[3:0]), 64'h9);
        chk("sof40_queue_empty", 64'(exp_q.size()), 64'd0);

        // STOP mid-capture: frame finishes, then IDLE ignores the next sof
        random_frame();
        build_words();
        exp_done++;
        send_range(0, 63, -1, 1'b0);
        command(C_STOP);
        send_range(64, FP - 1, -1, 1'b0);
        wait_done("frame_done_stop");
        chk("idle_after_stop", 64'(debug[2:0]), 64'd0);
        snap = words_seen;
        random_frame();
        send_range(0, FP - 1, -1, 1'b0);
        repeat (10) tick();
        chk("idle_ignores_words", 64'(words_seen), 64'(snap));
        chk("idle_no_valid", 64'(wdata_valid), 64'd0);
        chk("idle_no_done", 64'(got_done), 64'(exp_done));

        // Burst threshold at 15 vs 16 held words
        command(C_START);
        fixed_ready = 1'b0;
        repeat (2) tick();
        random_frame();
        build_words();
        exp_done++;
        send_range(0, 119, -1, 1'b0);
        repeat (4) tick();
        chk("burst_at_15", 64'(wdata_burst_valid), 64'd0);
        chk("valid_at_15", 64'(wdata_valid), 64'd1);
        send_range(120, FP - 1, -1, 1'b0);
        repeat (4) tick();
        chk("burst_at_16", 64'(wdata_burst_valid), 64'd1);
        chk("drain_state", 64'(debug[2:0]), 64'd3);
        fixed_ready = 1'b1;
        wait_done("frame_done_burst");

        // Reset mid-frame
        random_frame();
        build_words();
        send_range(0, 59, -1, 1'b0);
        fixed_ready = 1'b0;
        repeat (3) tick();
        rst = 1'b1;
        tick();
        check_reset_outputs("midrst");
        exp_q.delete();
        rst = 1'b0;
        tick();
        fixed_ready = 1'b1;
        command(C_START);
        random_frame();
        junk(3);
        build_words();
        exp_done++;
        send_range(0, FP - 1, -1, 1'b1);
        wait_done("frame_done_after_rst");
        chk("after_rst_queue_empty", 64'(exp_q.size()), 64'd0);

        // Overflow on the larger-frame instance: 65 words offered, 64 held
        b_cmd = C_START;
        b_cmd_valid = 1'b1;
        tick();
        b_cmd_valid = 1'b0;
        for (int i = 0; i < 64 * 8 + 8; i++) begin
            b_pix_valid = 1'b1;
            b_pix_sof   = (i == 0);
            b_pix_data  = 8'(i);
            tick();
        end
        b_pix_valid = 1'b0;
        b_pix_sof   = 1'b0;
        repeat (4) tick();
        chk("b_overflow", 64'(b_overflow_err), 64'd1);
        chk("b_burst", 64'(b_wdata_burst_valid), 64'd1);
        chk("b_debug", 64'(b_debug), 64'h12);
        b_wdata_ready = 1'b1;
        n = 0;
        while (b_wdata_valid && n < 100) begin
            logic [63:0] bw;
            for (int j = 0; j < 8; j++) bw[8*j +: 8] = 8'(8 * n + j);
            chk("b_word", b_wdata, bw);
            tick();
            n++;
        end
        chk("b_words_held", 64'(n), 64'd64);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
